// File: rtl/route_compute.sv
// Dimension-ordered (X, Y, Z) route computation stage for a 3D mesh router.
// Decodes the head flit, latches its route for the rest of the packet and drops malformed flits.
module route_compute #(
    parameter logic [2:0]  X         = 3'd0,
    parameter logic [2:0]  Y         = 3'd0,
    parameter logic [2:0]  Z         = 3'd0,
    parameter int unsigned FLIT_SIZE = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [FLIT_SIZE-1:0] q_data,
    input  logic                 q_empty,
    output logic                 q_deq,
    output logic [FLIT_SIZE-1:0] out_flit,
    output logic [6:0]           out_port,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [7:0]           err_cnt
);

    typedef enum logic [1:0] {StIdle, StActive, StDrop} state_t;

    localparam logic [1:0] TypeHead   = 2'b00;
    localparam logic [1:0] TypeBody   = 2'b01;
    localparam logic [1:0] TypeTail   = 2'b10;
    localparam logic [1:0] TypeSingle = 2'b11;

    state_t               state_q, state_d;
    logic [6:0]           route_q;
    logic [FLIT_SIZE-1:0] flit_q;
    logic [6:0]           port_q;
    logic                 valid_q;
    logic [7:0]           err_q;
    logic                 started_q;

    logic [1:0] flit_type;
    logic [8:0] dst;
    logic [2:0] dx, dy, dz;
    logic       check_ok;
    logic [6:0] route_calc;
    logic [6:0] route_sel;
    logic       fwd;
    logic       use_latched;
    logic       latch_route;
    logic       count_err;
    logic       slot_free;

    assign flit_type = q_data[FLIT_SIZE-1 -: 2];
    assign dst       = q_data[FLIT_SIZE-3 -: 9];
    assign dx        = dst[8:6];
    assign dy        = dst[5:3];
    assign dz        = dst[2:0];
    assign check_ok  = (q_data[FLIT_SIZE-12] == ^dst);

    // Bit order {ZN, ZP, YN, YP, XN, XP, LOCAL}
    always_comb begin
        route_calc = '0;
        if (dx > X)      route_calc[1] = 1'b1;
        else if (dx < X) route_calc[2] = 1'b1;
        else if (dy > Y) route_calc[3] = 1'b1;
        else if (dy < Y) route_calc[4] = 1'b1;
        else if (dz > Z) route_calc[5] = 1'b1;
        else if (dz < Z) route_calc[6] = 1'b1;
        else             route_calc[0] = 1'b1;
    end

    // state_d is the state taken if the head flit is dequeued this cycle
    always_comb begin
        fwd         = 1'b0;
        use_latched = 1'b0;
        latch_route = 1'b0;
        count_err   = 1'b0;
        state_d     = state_q;
        unique case (state_q)
            StIdle: begin
                unique case (flit_type)
                    TypeHead: begin
                        if (check_ok) begin
                            fwd         = 1'b1;
                            latch_route = 1'b1;
                            state_d     = StActive;
                        end else begin
                            count_err = 1'b1;
                            state_d   = StDrop;
                        end
                    end
                    TypeSingle: begin
                        if (check_ok) fwd = 1'b1;
                        else          count_err = 1'b1;
                    end
                    default: count_err = 1'b1;
                endcase
            end
            StActive: begin
                unique case (flit_type)
                    TypeBody: begin
                        fwd         = 1'b1;
                        use_latched = 1'b1;
                    end
                    TypeTail: begin
                        fwd         = 1'b1;
                        use_latched = 1'b1;
                        state_d     = StIdle;
                    end
                    default: count_err = 1'b1;
                endcase
            end
            StDrop: begin
                if (flit_type == TypeTail || flit_type == TypeSingle) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    assign route_sel = use_latched ? route_q : route_calc;
    assign slot_free = !valid_q || out_ready;
    // Discards drain regardless of the output slot; started_q holds off the first cycle after reset
    assign q_deq     = started_q && !q_empty && (!fwd || slot_free);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= StIdle;
            route_q   <= '0;
            flit_q    <= '0;
            port_q    <= '0;
            valid_q   <= 1'b0;
            err_q     <= '0;
            started_q <= 1'b0;
        end else begin
            started_q <= 1'b1;
            if (q_deq) state_q <= state_d;
            if (q_deq && latch_route) route_q <= route_calc;
            if (q_deq && fwd) begin
                valid_q <= 1'b1;
                flit_q  <= q_data;
                port_q  <= route_sel;
            end else if (out_ready) begin
                valid_q <= 1'b0;
            end
            if (q_deq && count_err && err_q != 8'hFF) err_q <= err_q + 8'd1;
        end
    end

    assign out_flit  = flit_q;
    assign out_port  = port_q;
    assign out_valid = valid_q;
    assign err_cnt   = err_q;

endmodule

// File: tb/tb_route_compute.sv
// Scoreboard bench for route_compute at X=Y=Z=1: a FWFT queue model feeds the DUT,
// a behavioural packet model predicts forwarded flits and the error count.
module tb_route_compute;

    localparam logic [6:0] PLocal = 7'b0000001;
    localparam logic [6:0] PXp    = 7'b0000010;
    localparam logic [6:0] PXn    = 7'b0000100;
    localparam logic [6:0] PYp    = 7'b0001000;
    localparam logic [6:0] PYn    = 7'b0010000;
    localparam logic [6:0] PZp    = 7'b0100000;
    localparam logic [6:0] PZn    = 7'b1000000;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] q_data;
    logic        q_empty;
    logic        q_deq;
    logic [31:0] out_flit;
    logic [6:0]  out_port;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [7:0]  err_cnt;

    route_compute #(.X(3'd1), .Y(3'd1), .Z(3'd1), .FLIT_SIZE(32)) dut (
        .clk(clk), .rst(rst), .q_data(q_data), .q_empty(q_empty), .q_deq(q_deq),
        .out_flit(out_flit), .out_port(out_port), .out_valid(out_valid),
        .out_ready(out_ready), .err_cnt(err_cnt)
    );

    always #5 clk = ~clk;

    logic [31:0] fifo_mem [0:1023];
    logic [9:0]  wr_ptr = '0;
    logic [9:0]  rd_ptr = '0;
    assign q_empty = (wr_ptr == rd_ptr);
    assign q_data  = fifo_mem[rd_ptr];

    logic [38:0] exp_q [$];
    int          n_cmp = 0;
    int          n_bad = 0;
    int          deq_cnt = 0;
    int          m_state = 0;   // 0 idle, 1 active, 2 drop
    logic [6:0]  m_route = '0;
    logic [7:0]  m_err = '0;

    always @(posedge clk) begin
        if (!rst) rd_ptr <= wr_ptr;
        else if (q_deq) rd_ptr <= rd_ptr + 10'd1;
    end

    always @(negedge clk) begin
        logic [38:0] e;
        if (rst) begin
            if (q_deq) begin
                deq_cnt++;
                n_cmp++;
                if (q_empty) begin
                    n_bad++;
                    $display("FAIL deq_when_empty: q_deq=%b q_empty=%b want no deq", q_deq, q_empty);
                end
            end
            if (out_valid && out_ready) begin
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_bad++;
                    $display("FAIL unexpected_out: got flit=%h port=%b want none", out_flit, out_port);
                end else begin
                    e = exp_q.pop_front();
                    if ({out_port, out_flit} !== e) begin
                        n_bad++;
                        $display("FAIL out_data: got port=%b flit=%h want port=%b flit=%h",
                                 out_port, out_flit, e[38:32], e[31:0]);
                    end
                end
            end
        end
    end

    function automatic logic [31:0] mk(input logic [1:0] t, input logic [2:0] x, input logic [2:0] y,
                                       input logic [2:0] z, input logic bad, input logic [19:0] pl);
        logic [8:0] d;
        d = {x, y, z};
        return {t, d, (^d) ^ bad, pl};
    endfunction

    function automatic logic [6:0] model_route(input logic [8:0] d);
        if (d[8:6] > 3'd1) return PXp;
        if (d[8:6] < 3'd1) return PXn;
        if (d[5:3] > 3'd1) return PYp;
        if (d[5:3] < 3'd1) return PYn;
        if (d[2:0] > 3'd1) return PZp;
        if (d[2:0] < 3'd1) return PZn;
        return PLocal;
    endfunction

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic model_err_inc();
        if (m_err != 8'd255) m_err = m_err + 8'd1;
    endtask

    task automatic push(input logic [31:0] f);
        logic [1:0] t;
        logic [8:0] d;
        logic       ok;
        fifo_mem[wr_ptr] = f;
        wr_ptr = wr_ptr + 10'd1;
        t  = f[31:30];
        d  = f[29:21];
        ok = (f[20] == ^d);
        case (m_state)
            0: begin
                if (t == 2'b00 && ok) begin
                    m_route = model_route(d);
                    exp_q.push_back({m_route, f});
                    m_state = 1;
                end else if (t == 2'b11 && ok) begin
                    exp_q.push_back({model_route(d), f});
                end else begin
                    model_err_inc();
                    if (t == 2'b00) m_state = 2;
                end
            end
            1: begin
                if (t == 2'b01) exp_q.push_back({m_route, f});
                else if (t == 2'b10) begin
                    exp_q.push_back({m_route, f});
                    m_state = 0;
                end else model_err_inc();
            end
            default: if (t == 2'b10 || t == 2'b11) m_state = 0;
        endcase
    endtask

    task automatic wait_idle();
        bit done = 0;
        for (int i = 0; i < 2000 && !done; i++) begin
            @(negedge clk);
            if (q_empty && exp_q.size() == 0 && !out_valid) done = 1;
        end
        n_cmp++;
        if (!done) begin
            n_bad++;
            $display("FAIL drain_timeout: pending=%0d out_valid=%b want drained", exp_q.size(), out_valid);
        end
    endtask

    task automatic check_err(input string name);
        n_cmp++;
        if (err_cnt !== m_err) begin
            n_bad++;
            $display("FAIL %s: err_cnt=%0d want %0d", name, err_cnt, m_err);
        end
    endtask

    task automatic test_reset();
        #1;
        n_cmp++;
        if ({out_valid, q_deq, out_flit, out_port, err_cnt} !== '0) begin
            n_bad++;
            $display("FAIL reset_outputs: valid=%b deq=%b flit=%h port=%b err=%0d want all 0",
                     out_valid, q_deq, out_flit, out_port, err_cnt);
        end
        repeat (3) tick();
        out_ready = 1'b1;
        push(mk(2'b11, 3'd1, 3'd1, 3'd1, 1'b0, 20'h00001));
        rst = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (q_deq !== 1'b0) begin
            n_bad++;
            $display("FAIL first_cycle_deq: q_deq=%b want 0", q_deq);
        end
        wait_idle();
        check_err("reset_err");
    endtask

    task automatic test_single();
        logic [31:0] f;
        bit          seen = 0;
        tick();
        f = mk(2'b11, 3'd3, 3'd0, 3'd5, 1'b0, 20'hABCDE);
        push(f);
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            if (q_deq) seen = 1;
        end
        @(negedge clk);
        n_cmp++;
        if (!seen || out_valid !== 1'b1 || out_flit !== f || out_port !== PXp) begin
            n_bad++;
            $display("FAIL single_latency: deq=%b valid=%b flit=%h port=%b want 1 1 %h %b",
                     seen, out_valid, out_flit, out_port, f, PXp);
        end
        wait_idle();
    endtask

    task automatic test_routes();
        tick();
        push(mk(2'b11, 3'd2, 3'd1, 3'd1, 1'b0, 20'h1));
        push(mk(2'b11, 3'd0, 3'd7, 3'd7, 1'b0, 20'h2));
        push(mk(2'b11, 3'd1, 3'd2, 3'd0, 1'b0, 20'h3));
        push(mk(2'b11, 3'd1, 3'd0, 3'd7, 1'b0, 20'h4));
        push(mk(2'b11, 3'd1, 3'd1, 3'd2, 1'b0, 20'h5));
        push(mk(2'b11, 3'd1, 3'd1, 3'd0, 1'b0, 20'h6));
        push(mk(2'b11, 3'd1, 3'd1, 3'd1, 1'b0, 20'h7));
        push(mk(2'b11, 3'd7, 3'd0, 3'd0, 1'b0, 20'h8));
        wait_idle();
        check_err("routes_err");
    endtask

    task automatic test_packet();
        bit seen = 0;
        tick();
        push(mk(2'b00, 3'd1, 3'd1, 3'd1, 1'b0, 20'h10));
        push(mk(2'b01, 3'd6, 3'd6, 3'd6, 1'b1, 20'h11));
        push(mk(2'b10, 3'd0, 3'd0, 3'd0, 1'b0, 20'h12));
        push(mk(2'b11, 3'd0, 3'd0, 3'd0, 1'b0, 20'h13));
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            if (out_valid) seen = 1;
        end
        for (int k = 0; k < 3; k++) begin
            n_cmp++;
            if (out_valid !== 1'b1 || out_port !== PLocal) begin
                n_bad++;
                $display("FAIL packet_local%0d: valid=%b port=%b want 1 %b", k, out_valid, out_port, PLocal);
            end
            @(negedge clk);
        end
        wait_idle();
    endtask

    task automatic test_bad_head();
        int d0;
        bit saw = 0;
        tick();
        d0 = deq_cnt;
        push(mk(2'b00, 3'd2, 3'd2, 3'd2, 1'b1, 20'h20));
        push(mk(2'b01, 3'd0, 3'd0, 3'd0, 1'b0, 20'h21));
        push(mk(2'b01, 3'd0, 3'd0, 3'd0, 1'b0, 20'h22));
        push(mk(2'b10, 3'd0, 3'd0, 3'd0, 1'b0, 20'h23));
        repeat (15) begin
            @(negedge clk);
            if (out_valid) saw = 1;
        end
        n_cmp++;
        if (deq_cnt - d0 != 4 || saw || err_cnt !== m_err) begin
            n_bad++;
            $display("FAIL bad_head: deqs=%0d out_valid_seen=%b err=%0d want 4 0 %0d",
                     deq_cnt - d0, saw, err_cnt, m_err);
        end
    endtask

    task automatic test_active_errors();
        tick();
        push(mk(2'b00, 3'd3, 3'd3, 3'd3, 1'b0, 20'h30));
        push(mk(2'b11, 3'd0, 3'd0, 3'd0, 1'b0, 20'h31));
        push(mk(2'b00, 3'd0, 3'd0, 3'd0, 1'b0, 20'h32));
        push(mk(2'b01, 3'd0, 3'd0, 3'd0, 1'b0, 20'h33));
        push(mk(2'b10, 3'd0, 3'd0, 3'd0, 1'b0, 20'h34));
        push(mk(2'b01, 3'd0, 3'd0, 3'd0, 1'b0, 20'h35));
        push(mk(2'b10, 3'd0, 3'd0, 3'd0, 1'b0, 20'h36));
        push(mk(2'b11, 3'd1, 3'd1, 3'd1, 1'b1, 20'h37));
        wait_idle();
        check_err("active_err");
    endtask

    task automatic test_backpressure();
        logic [31:0] h;
        int          d0;
        tick();
        out_ready = 1'b0;
        d0 = deq_cnt;
        h = mk(2'b00, 3'd2, 3'd1, 3'd1, 1'b0, 20'h40);
        push(h);
        push(mk(2'b01, 3'd0, 3'd0, 3'd0, 1'b0, 20'h41));
        push(mk(2'b10, 3'd0, 3'd0, 3'd0, 1'b0, 20'h42));
        @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            n_cmp++;
            if (out_valid !== 1'b1 || out_flit !== h || out_port !== PXp) begin
                n_bad++;
                $display("FAIL hold_stable%0d: valid=%b flit=%h port=%b want 1 %h %b",
                         i, out_valid, out_flit, out_port, h, PXp);
            end
        end
        n_cmp++;
        if (deq_cnt - d0 != 1) begin
            n_bad++;
            $display("FAIL stall_deqs: deqs=%0d want 1", deq_cnt - d0);
        end
        tick();
        out_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            n_cmp++;
            if (out_valid !== 1'b1) begin
                n_bad++;
                $display("FAIL release_stream%0d: valid=%b want 1", k, out_valid);
            end
        end
        wait_idle();
    endtask

    task automatic test_back_to_back();
        bit seen = 0;
        tick();
        for (int i = 0; i < 8; i++)
            push(mk(2'b11, 3'(i), 3'(7 - i), 3'(i + 2), 1'b0, 20'(i)));
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            if (out_valid) seen = 1;
        end
        for (int k = 1; k < 8; k++) begin
            @(negedge clk);
            n_cmp++;
            if (out_valid !== 1'b1) begin
                n_bad++;
                $display("FAIL back_to_back%0d: valid=%b want 1", k, out_valid);
            end
        end
        wait_idle();
    endtask

    task automatic test_random();
        for (int i = 0; i < 200; i++) begin
            tick();
            out_ready = 1'($urandom_range(0, 1));
            push(mk(2'($urandom_range(0, 3)), 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
                    3'($urandom_range(0, 7)), ($urandom_range(0, 3) == 0), 20'($urandom)));
        end
        push(mk(2'b10, 3'd0, 3'd0, 3'd0, 1'b0, 20'h5A5A5));
        tick();
        out_ready = 1'b1;
        wait_idle();
        check_err("random_err");
    endtask

    task automatic test_saturate();
        tick();
        for (int i = 0; i < 300; i++) push(mk(2'b01, 3'd0, 3'd0, 3'd0, 1'b0, 20'(i)));
        wait_idle();
        n_cmp++;
        if (err_cnt !== 8'd255 || m_err !== 8'd255) begin
            n_bad++;
            $display("FAIL saturate: err_cnt=%0d want 255", err_cnt);
        end
    endtask

    task automatic test_reset_mid();
        tick();
        out_ready = 1'b0;
        push(mk(2'b00, 3'd1, 3'd1, 3'd2, 1'b0, 20'h60));
        push(mk(2'b01, 3'd0, 3'd0, 3'd0, 1'b0, 20'h61));
        repeat (3) tick();
        rst = 1'b0;
        #1;
        n_cmp++;
        if ({out_valid, q_deq, out_flit, out_port, err_cnt} !== '0) begin
            n_bad++;
            $display("FAIL midreset_outputs: valid=%b deq=%b flit=%h port=%b err=%0d want all 0",
                     out_valid, q_deq, out_flit, out_port, err_cnt);
        end
        exp_q.delete();
        m_state = 0;
        m_err   = '0;
        repeat (2) tick();
        rst = 1'b1;
        out_ready = 1'b1;
        push(mk(2'b01, 3'd0, 3'd0, 3'd0, 1'b0, 20'h62));
        wait_idle();
        check_err("midreset_err");
    endtask

    initial begin
        test_reset();
        test_single();
        test_routes();
        test_packet();
        test_bad_head();
        test_active_errors();
        test_backpressure();
        test_back_to_back();
        test_random();
        test_saturate();
        test_reset_mid();
        repeat (2) tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
